bkram_sd_stream: RTL

- Parametrised backup-RAM streamer between the core's NVRAM dual-port buffer and the MiST user_io SD sector interface.
- On image mount, loads up to SECTORS 512-byte sectors from the mounted SAV image into the buffer. On request, writes them back.
- Over the fixed 16-sector top-level logic, adds:
  - transfer length clamped to the mounted image size;
  - a base-LBA offset;
  - one-deep queueing of load/save requests;
  - abort on ROM download.

---
 rtl/bkram_sd_stream_if.sv | 13 +
 rtl/bkram_sd_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bkram_sd_stream_if.sv
// SD sector handshake between the backup-RAM streamer (master) and user_io (slave).
interface bkram_sd_stream_if #(
  parameter int SECT_W = 4
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [SECT_W-1:0] buf_sect;

  modport master (output sd_lba, sd_rd, sd_wr, buf_sect, input sd_ack);
  modport slave  (input sd_lba, sd_rd, sd_wr, buf_sect, output sd_ack);
endinterface

// File: rtl/bkram_sd_stream.sv
// Streams up to 2**SECT_W backup-RAM sectors between the NVRAM buffer and user_io SD.
// Optional macro BK_DIRTY_EN: per-sector dirty bits so a save writes only modified sectors.
module bkram_sd_stream #(
  parameter int          SECT_W   = 4,
  parameter logic [31:0] LBA_BASE = 32'd0
) (
  input  logic                clk_sys,
  input  logic                RESET_n,
  input  logic                img_mounted,
  input  logic [31:0]         img_size,
  input  logic                download,
  input  logic                save_req,
  input  logic                nv_we,
  input  logic [SECT_W+8:0]   nv_addr,
  bkram_sd_stream_if.master   sd,
  output logic                bk_ena,
  output logic                bk_busy,
  output logic                bk_reset,
  output logic                dirty_any
);
  localparam int SECTORS = 1 << SECT_W;
  localparam int NW      = SECT_W + 1;

  typedef enum logic [2:0] {IDLE, SCAN, REQ, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [SECT_W-1:0] idx_q, idx_d;
  logic              dir_q, dir_d;            // 1 = load, 0 = save
  logic [NW-1:0]     n_run_q, n_run_d;        // length latched at start
  logic [NW-1:0]     n_sect_q;
  logic              bk_ena_q, pend_load_q, pend_save_q;
  logic              mnt_q, save_q, dl_q, ack_q;
  logic              start_load, start_save;
  logic [23:0]       sz_round;
  logic [NW-1:0]     n_calc;

  wire mnt_rise  = img_mounted & ~mnt_q;
  wire save_rise = save_req & ~save_q;
  wire dl_rise   = download & ~dl_q;
  wire ack_rise  = sd.sd_ack & ~ack_q;
  wire ack_fall  = ~sd.sd_ack & ack_q;
  wire last      = ({1'b0, idx_q} == (n_run_q - 1'b1));

  // Sector count rounded up, then clamped to the buffer size.
  assign sz_round = {1'b0, img_size[31:9]} + {23'd0, |img_size[8:0]};
  assign n_calc   = (sz_round >= 24'(SECTORS)) ? NW'(SECTORS) : sz_round[NW-1:0];

`ifdef BK_DIRTY_EN
  logic [SECTORS-1:0] dirty_q, dirty_d, rng;

  always_comb begin
    rng = '0;
    for (int i = 0; i < SECTORS; i++) rng[i] = (i < int'(n_sect_q));
  end

  always_comb begin
    dirty_d = dirty_q;
    if (state_q == DONE && dir_q) dirty_d = '0;
    if (state_q == XFER && ack_fall && !dir_q) dirty_d[idx_q] = 1'b0;
    // A core write in the same cycle as the write-back must keep the sector dirty.
    if (nv_we) dirty_d[nv_addr[SECT_W+8:9]] = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) dirty_q <= '0;
    else          dirty_q <= dirty_d;

  assign dirty_any = |dirty_q;
`else
  logic unused_nv;
  assign unused_nv = ^{nv_we, nv_addr};
  assign dirty_any = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      n_run_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      n_run_q <= n_run_d;
    end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    n_run_d    = n_run_q;
    start_load = 1'b0;
    start_save = 1'b0;
    case (state_q)
      IDLE: begin
        if (bk_ena_q && pend_load_q) begin
          start_load = 1'b1;
          dir_d      = 1'b1;
          idx_d      = '0;
          n_run_d    = n_sect_q;
          state_d    = REQ;
        end else if (bk_ena_q && pend_save_q) begin
          start_save = 1'b1;
          dir_d      = 1'b0;
          idx_d      = '0;
          n_run_d    = n_sect_q;
`ifdef BK_DIRTY_EN
          state_d    = (|(dirty_q & rng)) ? SCAN : DONE;
`else
          state_d    = REQ;
`endif
        end
      end
      SCAN: begin
`ifdef BK_DIRTY_EN
        if (!bk_ena_q)             state_d = IDLE;
        else if (dirty_q[idx_q])   state_d = REQ;
        else if (last)             state_d = DONE;
        else                       idx_d   = idx_q + 1'b1;
`else
        state_d = IDLE;
`endif
      end
      REQ:  if (ack_rise) state_d = XFER;
      XFER: begin
        if (ack_fall) begin
          if (!bk_ena_q)  state_d = IDLE;
          else if (last)  state_d = DONE;
          else begin
            idx_d = idx_q + 1'b1;
`ifdef BK_DIRTY_EN
            state_d = dir_q ? REQ : SCAN;
`else
            state_d = REQ;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sd.sd_rd = (state_q == REQ) &&  dir_q;
    sd.sd_wr = (state_q == REQ) && !dir_q;
    bk_busy  = (state_q != IDLE);
    bk_reset = (state_q == DONE) && dir_q;
  end

  assign sd.sd_lba   = LBA_BASE + 32'(idx_q);
  assign sd.buf_sect = idx_q;
  assign bk_ena      = bk_ena_q;

  // Request queue and mount state; edges arriving mid-transfer only set pending flags.
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      mnt_q       <= 1'b0;
      save_q      <= 1'b0;
      dl_q        <= 1'b0;
      ack_q       <= 1'b0;
      bk_ena_q    <= 1'b0;
      pend_load_q <= 1'b0;
      pend_save_q <= 1'b0;
      n_sect_q    <= '0;
    end else begin
      mnt_q  <= img_mounted;
      save_q <= save_req;
      dl_q   <= download;
      ack_q  <= sd.sd_ack;
      if (start_load) pend_load_q <= 1'b0;
      if (start_save) pend_save_q <= 1'b0;
      if (mnt_rise) begin
        if (img_size != 32'd0) begin
          bk_ena_q    <= 1'b1;
          pend_load_q <= 1'b1;
          n_sect_q    <= n_calc;
        end else begin
          bk_ena_q    <= 1'b0;
        end
      end
      if (save_rise && bk_ena_q) pend_save_q <= 1'b1;
      if (dl_rise) begin
        bk_ena_q    <= 1'b0;
        pend_load_q <= 1'b0;
        pend_save_q <= 1'b0;
      end
    end
endmodule
